// File: rtl/bw_ctu_pad_mon_if.sv
// Pad-monitor bus: synchronised pad-cluster inputs and CTU status outputs.
interface bw_ctu_pad_mon_if #(
   parameter int NUM_TSR = 2,
   parameter int CNT_W   = 12
);
   localparam int SCH_W = (NUM_TSR > 1) ? $clog2(NUM_TSR) : 1;

   logic                     mon_en;
   logic                     jclk_p_sync;
   logic                     jclk_n_sync;
   logic [NUM_TSR-1:0]       tsr_cmp;
   logic [CNT_W-1:0]         tsr_thresh;
   logic [NUM_TSR*CNT_W-1:0] tsr_val;
   logic [NUM_TSR-1:0]       tsr_vld;
   logic [NUM_TSR-1:0]       tsr_alarm;
   logic [SCH_W-1:0]         scan_ch;
   logic                     jclk_ok;
   logic                     jclk_fault;
   logic                     busy;

   // driver side (pad cluster / CTU control)
   modport master (
      output mon_en, jclk_p_sync, jclk_n_sync, tsr_cmp, tsr_thresh,
      input  tsr_val, tsr_vld, tsr_alarm, scan_ch, jclk_ok, jclk_fault, busy
   );

   // monitor side
   modport slave (
      input  mon_en, jclk_p_sync, jclk_n_sync, tsr_cmp, tsr_thresh,
      output tsr_val, tsr_vld, tsr_alarm, scan_ch, jclk_ok, jclk_fault, busy
   );
endinterface

// File: rtl/bw_ctu_pad_mon.sv
// CTU pad monitor: round-robin tempsensor duty measurement plus jclk
// edge-rate and complementarity checking over a fixed window.
module bw_ctu_pad_mon #(
   parameter int NUM_TSR  = 2,
   parameter int CNT_W    = 12,
   parameter int WIN      = 1024,
   parameter int SETTLE   = 8,
   parameter int EDGE_MIN = 100,
   parameter int EDGE_MAX = 400
) (
   input logic              jbus_clk,
   input logic              jbus_rst,
   bw_ctu_pad_mon_if.slave  mon
);
   localparam int SCH_W  = (NUM_TSR > 1) ? $clog2(NUM_TSR) : 1;
   localparam int PAD_W  = 2 ** SCH_W;
   localparam int PH_MAX = (WIN > SETTLE) ? WIN : SETTLE;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEAS, S_UPD} state_t;

   state_t                   state_q, state_d;
   logic [PH_W-1:0]          ph_q, ph_d;
   logic [CNT_W-1:0]         duty_q, duty_d, edge_q, edge_d;
   logic [SCH_W-1:0]         ch_q, ch_d;
   logic                     jp_q, eq_q, fault_q, ok_q;
   logic [NUM_TSR*CNT_W-1:0] val_q;
   logic [NUM_TSR-1:0]       vld_q, alarm_q;
   logic [PAD_W-1:0]         cmp_pad;
   logic                     upd, p_rise, pn_eq;

   // zero-extend so any scan_ch encoding is a legal index
   assign cmp_pad = PAD_W'(mon.tsr_cmp);
   assign upd     = (state_q == S_UPD);
   assign p_rise  = mon.jclk_p_sync & ~jp_q;
   assign pn_eq   = (mon.jclk_p_sync == mon.jclk_n_sync);

   // next state and phase counter; mon_en only matters at IDLE and UPD
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      case (state_q)
         S_IDLE: if (mon.mon_en) begin
            state_d = S_SETTLE;
            ph_d    = '0;
         end
         S_SETTLE: if (ph_q == PH_W'(SETTLE - 1)) begin
            state_d = S_MEAS;
            ph_d    = '0;
         end else begin
            ph_d = ph_q + 1'b1;
         end
         S_MEAS: if (ph_q == PH_W'(WIN - 1)) begin
            state_d = S_UPD;
            ph_d    = '0;
         end else begin
            ph_d = ph_q + 1'b1;
         end
         S_UPD: begin
            state_d = mon.mon_en ? S_SETTLE : S_IDLE;
            ph_d    = '0;
         end
         default: begin
            state_d = S_IDLE;
            ph_d    = '0;
         end
      endcase
   end

   // saturating duty/edge counters, held clear through SETTLE
   always_comb begin
      duty_d = duty_q;
      edge_d = edge_q;
      ch_d   = ch_q;
      if (state_q == S_SETTLE) begin
         duty_d = '0;
         edge_d = '0;
      end else if (state_q == S_MEAS) begin
         if (cmp_pad[ch_q] && duty_q != CNT_SAT) duty_d = duty_q + 1'b1;
         if (p_rise && edge_q != CNT_SAT)        edge_d = edge_q + 1'b1;
      end
      if (upd) ch_d = (ch_q == SCH_W'(NUM_TSR - 1)) ? '0 : ch_q + 1'b1;
   end

   // control/counter state and jclk pair history
   always_ff @(posedge jbus_clk) begin
      if (jbus_rst) begin
         state_q <= S_IDLE;
         ph_q    <= '0;
         duty_q  <= '0;
         edge_q  <= '0;
         ch_q    <= '0;
         jp_q    <= 1'b0;
         eq_q    <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         duty_q  <= duty_d;
         edge_q  <= edge_d;
         ch_q    <= ch_d;
         jp_q    <= mon.jclk_p_sync;
         eq_q    <= pn_eq;
         if (pn_eq && eq_q) fault_q <= 1'b1;
      end
   end

   // per-channel result commit in UPD; threshold sampled only here
   always_ff @(posedge jbus_clk) begin
      if (jbus_rst) begin
         val_q   <= '0;
         vld_q   <= '0;
         alarm_q <= '0;
         ok_q    <= 1'b0;
      end else if (upd) begin
         for (int i = 0; i < NUM_TSR; i++) begin
            if (ch_q == SCH_W'(i)) begin
               val_q[i*CNT_W +: CNT_W] <= duty_q;
               vld_q[i]                <= 1'b1;
               alarm_q[i]              <= (duty_q > mon.tsr_thresh);
            end
         end
         ok_q <= (edge_q >= CNT_W'(EDGE_MIN)) && (edge_q <= CNT_W'(EDGE_MAX));
      end
   end

   assign mon.tsr_val    = val_q;
   assign mon.tsr_vld    = vld_q;
   assign mon.tsr_alarm  = alarm_q;
   assign mon.scan_ch    = ch_q;
   assign mon.jclk_ok    = ok_q;
   assign mon.jclk_fault = fault_q;
   assign mon.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_bw_ctu_pad_mon.sv
// Scoreboard bench for bw_ctu_pad_mon: the driver predicts each window's
// committed results from the timeline; a monitor checks on each commit.
module tb_bw_ctu_pad_mon;
   localparam int NT = 3, CW = 12, WIN = 1024, ST = 8, EMIN = 100, EMAX = 400;
   localparam int SW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bw_ctu_pad_mon_if #(.NUM_TSR(NT), .CNT_W(CW)) bus();

   bw_ctu_pad_mon #(.NUM_TSR(NT), .CNT_W(CW), .WIN(WIN), .SETTLE(ST),
                    .EDGE_MIN(EMIN), .EDGE_MAX(EMAX))
      dut (.jbus_clk(clk), .jbus_rst(rst), .mon(bus));

   typedef struct {
      logic [NT*CW-1:0] val;
      logic [NT-1:0]    vld;
      logic [NT-1:0]    alarm;
      logic [SW-1:0]    ch;
      logic             ok;
      logic             fault;
   } exp_t;

   exp_t q[$];
   int n_chk = 0, n_pass = 0;

   // reference model state
   logic [NT*CW-1:0] m_val;
   logic [NT-1:0]    m_vld, m_alarm;
   int               m_ch;
   logic             m_ok, m_fault, prev_p, prev_eq;
   logic [CW-1:0]    thr;
   int               tick;
   bit               mon_hold;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   task automatic model_reset();
      m_val = '0; m_vld = '0; m_alarm = '0; m_ch = 0; m_ok = 0; m_fault = 0;
      prev_p = 0; prev_eq = 0;
   endtask

   // drive one clock's inputs; rise reports a p rising edge seen at this edge
   task automatic cyc(input logic en, input logic r, input logic [NT-1:0] cmp,
                      input logic p, input logic n, output logic rise);
      @(negedge clk);
      rst = r; bus.mon_en = en; bus.tsr_cmp = cmp;
      bus.jclk_p_sync = p; bus.jclk_n_sync = n; bus.tsr_thresh = thr;
      tick++;
      if (r) begin
         prev_p = 0; prev_eq = 0; m_fault = 0; rise = 0;
      end else begin
         rise = p & ~prev_p;
         if (p == n && prev_eq) m_fault = 1;
         prev_eq = (p == n);
         prev_p  = p;
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_val"},   bus.tsr_val,    '0);
      chk({tag, "_vld"},   bus.tsr_vld,    '0);
      chk({tag, "_alarm"}, bus.tsr_alarm,  '0);
      chk({tag, "_ch"},    bus.scan_ch,    '0);
      chk({tag, "_ok"},    bus.jclk_ok,    '0);
      chk({tag, "_fault"}, bus.jclk_fault, '0);
      chk({tag, "_busy"},  bus.busy,       '0);
   endtask

   task automatic do_reset(input int ncyc);
      logic rise;
      mon_hold = 1;
      for (int i = 0; i < ncyc; i++) cyc(0, 1, '0, 0, 1, rise);
      model_reset();
      cyc(0, 0, '0, 0, 1, rise);
      check_zero("reset");
      for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 1, rise);
      mon_hold = 0;
   endtask

   // One measurement window as seen from outside: pre cycles before MEAS
   // (1+SETTLE from idle, SETTLE back-to-back), WIN counted cycles, one commit.
   // duty<0 gives random comparator data; t is the threshold in force at commit.
   task automatic window(input int pre, input int duty, input int half, input int t,
                         input bit drop, input int eq_at, input int eq_len,
                         input int abort_at);
      int ch, dcnt, ecnt;
      logic rise, p, n, en;
      logic [NT-1:0] cmp;
      exp_t e;
      ch = m_ch; dcnt = 0; ecnt = 0;
      for (int c = 0; c < pre + WIN + 1; c++) begin
         int k;
         k = c - pre;
         if (c == abort_at) return;
         cmp = NT'($urandom);
         if (k >= 0 && k < WIN && duty >= 0) cmp[ch] = (k < duty);
         p = ((tick / half) % 2) == 1;
         n = ~p;
         if (c >= eq_at && c < eq_at + eq_len) n = p;
         en = !(drop && k >= WIN / 2);
         if (k == WIN / 2) thr = CW'(t);
         cyc(en, 0, cmp, p, n, rise);
         if (k >= 0 && k < WIN) begin
            dcnt += int'(cmp[ch]);
            ecnt += int'(rise);
         end
         if (k == WIN / 2) chk("busy_meas", bus.busy, 1);
      end
      if (dcnt > 4095) dcnt = 4095;
      m_val[ch*CW +: CW] = CW'(dcnt);
      m_vld[ch]   = 1;
      m_alarm[ch] = (dcnt > int'(thr));
      m_ok        = (ecnt >= EMIN) && (ecnt <= EMAX);
      m_ch        = (ch + 1) % NT;
      e.val = m_val; e.vld = m_vld; e.alarm = m_alarm;
      e.ch = SW'(m_ch); e.ok = m_ok; e.fault = m_fault;
      q.push_back(e);
   endtask

   // monitor: a scan_ch advance marks a commit
   initial begin
      logic [SW-1:0] last;
      exp_t e;
      last = '0;
      forever begin
         @(negedge clk);
         if (mon_hold) last = bus.scan_ch;
         else if (bus.scan_ch !== last) begin
            last = bus.scan_ch;
            if (q.size() == 0) begin
               n_chk++;
               $display("FAIL commit_unexpected: got scan_ch %0d with no pending window", bus.scan_ch);
            end else begin
               e = q.pop_front();
               chk("tsr_val",    bus.tsr_val,    e.val);
               chk("tsr_vld",    bus.tsr_vld,    e.vld);
               chk("tsr_alarm",  bus.tsr_alarm,  e.alarm);
               chk("scan_ch",    bus.scan_ch,    e.ch);
               chk("jclk_ok",    bus.jclk_ok,    e.ok);
               chk("jclk_fault", bus.jclk_fault, e.fault);
            end
         end
      end
   end

   initial begin
      logic rise;
      mon_hold = 1; tick = 0; thr = '0;
      bus.mon_en = 0; bus.tsr_cmp = '0; bus.jclk_p_sync = 0; bus.jclk_n_sync = 1;
      bus.tsr_thresh = '0;
      model_reset();
      do_reset(3);

      window(1 + ST, WIN, 4, 512, 0, 100, 1, -1);       // ch0 full duty, single-cycle p==n
      window(ST, 300, 1, 300, 0, -1, 0, -1);            // ch1 duty==thresh, 512 edges
      window(ST, -1, 3, $urandom_range(0, WIN), 0, 500, 2, -1); // ch2, fault sets
      window(ST, -1, 5, $urandom_range(0, WIN), 0, -1, 0, -1);
      window(ST, 301, 2, 300, 0, -1, 0, -1);            // ch1 duty==thresh+1
      window(ST, -1, 8, $urandom_range(0, WIN), 0, -1, 0, -1);
      window(ST, -1, $urandom_range(1, 8), $urandom_range(0, WIN), 1, -1, 0, -1); // drop en

      for (int i = 0; i < 20; i++) cyc(0, 0, NT'($urandom), 0, 1, rise);
      chk("idle_busy", bus.busy, 0);
      chk("idle_scan_ch_held", bus.scan_ch, SW'(m_ch));

      window(1 + ST, -1, 4, $urandom_range(0, WIN), 0, -1, 0, -1);
      window(ST, -1, 4, $urandom_range(0, WIN), 0, -1, 0, ST + 500); // reset mid-MEAS
      do_reset(1);

      for (int i = 0; i < 4; i++)
         window((i == 0) ? 1 + ST : ST, -1, $urandom_range(1, 8),
                $urandom_range(0, WIN), 0, -1, 0, -1);

      for (int i = 0; i < 5; i++) cyc(0, 0, '0, 0, 1, rise);
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/bw_ctu_pad_mon.md
Name: bw_ctu_pad_mon

Overview:
- Parametrised monitor for the CTU analog pad cluster; successor to the fixed 2-channel jclk/tempsensor pad block.
- Scans NUM_TSR tempsensor comparator channels round-robin and measures each channel's duty (temperature proxy) over a fixed window.
- In the same window, checks the differential jclk pair for edge rate and complementarity.
- Sits between the synchronised pad-cluster outputs and CTU status/alarm logic.

Parameters:
- NUM_TSR, 2, number of tempsensor channels (1..16).
- CNT_W, 12, width of duty and edge counters; 2^CNT_W-1 >= WIN.
- WIN, 1024, measurement window length in jbus_clk cycles.
- SETTLE, 8, discard cycles after each channel switch (>=1).
- EDGE_MIN, 100, minimum jclk_p rising edges per window for jclk_ok.
- EDGE_MAX, 400, maximum jclk_p rising edges per window for jclk_ok.

Ports:
- jbus_clk  in  1  sole clock.
- jbus_rst  in  1  synchronous, active-high reset.
- mon_en  in  1  enable scanning; low returns the FSM to IDLE at the next window boundary.
- jclk_p_sync  in  1  jclk true leg, already synchronised to jbus_clk.
- jclk_n_sync  in  1  jclk complement leg, already synchronised.
- tsr_cmp  in  NUM_TSR  synchronised comparator outputs, one per channel.
- tsr_thresh  in  CNT_W  alarm threshold, shared by all channels.
- tsr_val  out  NUM_TSR*CNT_W  last duty count per channel; channel i occupies bits [i*CNT_W +: CNT_W].
- tsr_vld  out  NUM_TSR  channel i holds at least one completed measurement.
- tsr_alarm  out  NUM_TSR  last duty of channel i > tsr_thresh.
- scan_ch  out  max(1,$clog2(NUM_TSR))  channel currently selected.
- jclk_ok  out  1  last window's edge count was in [EDGE_MIN, EDGE_MAX].
- jclk_fault  out  1  sticky: p==n observed for 2 consecutive cycles.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (jbus_rst=1 at a jbus_clk edge): FSM=IDLE, scan_ch=0, all counters=0. All outputs are 0 after reset, including tsr_val, tsr_vld, tsr_alarm, jclk_ok, jclk_fault and busy. Reset overrides everything, including mid-window; partial counts are discarded.
- FSM states IDLE, SETTLE, MEAS, UPD:
  - IDLE: when mon_en=1, go to SETTLE next cycle.
  - SETTLE: runs exactly SETTLE cycles, then MEAS. No counting.
  - MEAS: runs exactly WIN cycles. duty_cnt increments each cycle tsr_cmp[scan_ch]=1. edge_cnt increments on each jclk_p_sync 0->1, using a registered previous value; that register is updated in every state.
  - UPD: one cycle, then SETTLE if mon_en=1, else IDLE.
- Counters saturate at 2^CNT_W-1. They clear on SETTLE entry.
- UPD actions, all visible the cycle after UPD:
  - tsr_val[scan_ch] <= duty_cnt.
  - tsr_vld[scan_ch] <= 1.
  - tsr_alarm[scan_ch] <= (duty_cnt > tsr_thresh). A duty equal to the threshold does not alarm.
  - jclk_ok <= EDGE_MIN <= edge_cnt <= EDGE_MAX.
  - scan_ch <= (scan_ch == NUM_TSR-1) ? 0 : scan_ch+1.
- mon_en deasserted during SETTLE or MEAS: the current window completes and UPD commits, then the FSM goes to IDLE. scan_ch is held; the next enable resumes at that channel.
- jclk_fault is independent of FSM state:
  - Sets when jclk_p_sync == jclk_n_sync on two consecutive cycles.
  - A single-cycle equality does not set it.
  - Clears only on jbus_rst.
- tsr_thresh is sampled in UPD only. Changing it does not re-evaluate stored alarms.
- NUM_TSR=1: scan_ch is constantly 0.
- busy=1 in SETTLE, MEAS and UPD.
- Per-channel result latency after mon_en rises: 1+SETTLE+WIN+1 cycles.

Test Plan:
1. Reset, mon_en=1, tsr_cmp[0]=1 constant, defaults. At cycle 1+8+1024+1: tsr_val[0]=1024, tsr_vld=2'b01, scan_ch=1. With tsr_thresh=512, tsr_alarm[0]=1.
2. tsr_cmp[1] high 300 of 1024 MEAS cycles, tsr_thresh=300. Required: tsr_val[1]=300, tsr_alarm[1]=0. Repeat with 301 high cycles: tsr_alarm[1]=1.
3. jclk_p_sync toggling every 4 cycles (128 rising edges/window) with n=~p. Required: jclk_ok=1, jclk_fault=0. Same test at a period of 2 cycles (512 edges): jclk_ok=0.
4. Force p==n for 1 cycle: jclk_fault stays 0. Force p==n for 2 cycles: jclk_fault=1 and remains 1 after the pair recovers, until jbus_rst.
5. NUM_TSR=3, mon_en held high for 4 windows. Required scan_ch sequence 0,1,2,0; tsr_vld=3'b111 after the third UPD.
6. Assert jbus_rst mid-MEAS: all outputs are 0 the next cycle. Drop mon_en mid-MEAS: UPD still commits, then busy=0 and scan_ch is held.
